clock_set_controller: RTL and testbench
=======================================

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 Parameter BLINK_DIV, default 25000000, clk cycles per blink half-period in SET state.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; one clock, asynchronous and active-high.
REQ-004 sec_tick  in  1  one-cycle pulse, once per second.
REQ-005 btn_set  in  1  debounced one-cycle pulse; toggles RUN/SET.
REQ-006 btn_next  in  1  debounced one-cycle pulse; advances edited digit.
REQ-007 btn_inc  in  1  debounced one-cycle pulse; increments edited digit.
REQ-008 mode  out  2  display mode: 2'b01 = RUN (24h), 2'b00 = SET.
REQ-009 location  out  2  edited digit: 0 = hours tens, 1 = hours units, 2 = minutes tens, 3 = minutes units.
REQ-010 hoursUpper, hoursLower, minutesUpper, minutesLower  out  4 each  BCD time digits.
REQ-011 seconds  out  6  binary seconds, 0..59.
REQ-012 blank  out  1  1 = blank the digit at location (blink phase).

Function
REQ-013 The block SHALL be a 2-state FSM: RUN and SET. All outputs SHALL be registered and SHALL reflect an input event on the cycle after the event.
REQ-014 In RUN, each sec_tick SHALL increment seconds. 59 SHALL wrap to 0 with a minute carry.
REQ-015 minutesLower SHALL count 0..9, with wrap carrying into minutesUpper. minutesUpper SHALL count 0..5, with wrap carrying into hours.
REQ-016 Hours SHALL count 00..23 in BCD. On a tick at 23:59:59 the time SHALL become 00:00:00, with all digits updated in the same cycle.
REQ-017 In RUN, btn_next and btn_inc SHALL be ignored, and mode SHALL be 2'b01, blank 0 and location 0.
REQ-018 btn_set in RUN SHALL enter SET with location 0 and seconds cleared to 0. The blink counter SHALL be cleared and blank set to 0.
REQ-019 In SET, sec_tick SHALL be ignored and time SHALL hold except for btn_inc edits.
REQ-020 btn_next in SET SHALL set location to (location+1) mod 4, so 3 wraps to 0.
REQ-021 btn_inc in SET SHALL increment the digit at location with the following wraps:
- hoursUpper: 0..2, 2 wraps to 0.
- hoursLower: 0..9 when hoursUpper<2; 0..3 when hoursUpper=2.
- minutesUpper: 0..5.
- minutesLower: 0..9.
REQ-022 btn_inc of hoursUpper from 1 to 2 with hoursLower>3 SHALL clamp hoursLower to 3 in the same cycle.
REQ-023 Digit increments in SET SHALL never carry into neighbouring digits.
REQ-024 btn_set in SET SHALL return to RUN with location 0 and blank 0. Seconds SHALL remain 0, and counting SHALL resume on the next sec_tick.
REQ-025 Simultaneous pulses SHALL be resolved by priority btn_set > btn_next > btn_inc, with only the highest acted on. A sec_tick coincident with btn_set in RUN SHALL be dropped.
REQ-026 In SET, a blink counter SHALL count clk cycles 0..BLINK_DIV-1 and toggle blank on wrap.
REQ-027 btn_next or btn_inc SHALL clear the blink counter and force blank to 0, so the edited digit is visible.
REQ-028 Digit registers SHALL never hold non-BCD or out-of-range values.

Reset
REQ-029 rst asserted SHALL immediately force: RUN state, mode 2'b01, location 0, all time digits 0, seconds 0, blank 0, blink counter 0.
REQ-030 rst asserted mid-edit or mid-count SHALL discard the in-progress state. Pulses present while rst is asserted SHALL be ignored.
REQ-031 After rst deasserts, the first rising clk edge SHALL process inputs normally.

Verification (sim with BLINK_DIV=4)
REQ-032 Rollover: preset 23:59:59 through SET, then RUN + 1 sec_tick -> 00:00:00, mode 01.
REQ-033 Hour clamp: SET, set HU=1, HL=9; location 0 btn_inc -> HU=2, HL=3; btn_inc -> HU=0, HL=3.
REQ-034 Navigation and blink:
- SET; 4 btn_next -> location 1,2,3,0.
- With no presses, blank toggles every 4 cycles.
- btn_inc -> blank 0 next cycle and counter restarts.
REQ-035 Priority: btn_set+btn_next+btn_inc in one SET cycle -> RUN, location 0, digits unchanged. sec_tick+btn_set in RUN -> SET, seconds 0, minutes unchanged.
REQ-036 Async reset: assert rst between clk edges during SET with time 12:34 -> outputs 00:00:00, mode 01, blank 0 before the next clk edge.
REQ-037 Range sweep: 60 btn_inc on each digit -> values stay within REQ-021 limits, with no carry to neighbours.

Source files
------------

// File: rtl/clock_set_controller.sv
// 24-hour HH:MM:SS clock with a button-driven set mode.
// RUN counts seconds. SET edits one BCD digit at a time and blinks the digit being edited.
module clock_set_controller #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       btn_set,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic [1:0] mode,
    output logic [1:0] location,
    output logic [3:0] hoursUpper,
    output logic [3:0] hoursLower,
    output logic [3:0] minutesUpper,
    output logic [3:0] minutesLower,
    output logic [5:0] seconds,
    output logic       blank
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [1:0] MODE_RUN = 2'b01;
    localparam logic [1:0] MODE_SET = 2'b00;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       mode_reg, mode_next;
    logic [1:0]       location_reg, location_next;
    logic [3:0]       hu_reg, hu_next;
    logic [3:0]       hl_reg, hl_next;
    logic [3:0]       mu_reg, mu_next;
    logic [3:0]       ml_reg, ml_next;
    logic [5:0]       sec_reg, sec_next;
    logic             blank_reg, blank_next;
    logic [CNT_W-1:0] blink_cnt_reg, blink_cnt_next;

    // Largest legal hours-units value depends on the hours-tens digit (20..23).
    logic [3:0] hl_limit;
    assign hl_limit = (hu_reg == 4'd2) ? 4'd3 : 4'd9;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RUN;
            mode_reg      <= MODE_RUN;
            location_reg  <= 2'd0;
            hu_reg        <= 4'd0;
            hl_reg        <= 4'd0;
            mu_reg        <= 4'd0;
            ml_reg        <= 4'd0;
            sec_reg       <= 6'd0;
            blank_reg     <= 1'b0;
            blink_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            location_reg  <= location_next;
            hu_reg        <= hu_next;
            hl_reg        <= hl_next;
            mu_reg        <= mu_next;
            ml_reg        <= ml_next;
            sec_reg       <= sec_next;
            blank_reg     <= blank_next;
            blink_cnt_reg <= blink_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        location_next  = location_reg;
        hu_next        = hu_reg;
        hl_next        = hl_reg;
        mu_next        = mu_reg;
        ml_next        = ml_reg;
        sec_next       = sec_reg;
        blank_next     = blank_reg;
        blink_cnt_next = blink_cnt_reg;

        case (state_reg)
            RUN: begin
                location_next  = 2'd0;
                blank_next     = 1'b0;
                blink_cnt_next = '0;
                mode_next      = MODE_RUN;
                if (btn_set) begin
                    // A tick arriving together with btn_set is deliberately lost.
                    state_next = SET;
                    mode_next  = MODE_SET;
                    sec_next   = 6'd0;
                end else if (sec_tick) begin
                    if (sec_reg == 6'd59) begin
                        sec_next = 6'd0;
                        if (ml_reg == 4'd9) begin
                            ml_next = 4'd0;
                            if (mu_reg == 4'd5) begin
                                mu_next = 4'd0;
                                if (hu_reg == 4'd2 && hl_reg == 4'd3) begin
                                    hu_next = 4'd0;
                                    hl_next = 4'd0;
                                end else if (hl_reg == 4'd9) begin
                                    hl_next = 4'd0;
                                    hu_next = hu_reg + 4'd1;
                                end else begin
                                    hl_next = hl_reg + 4'd1;
                                end
                            end else begin
                                mu_next = mu_reg + 4'd1;
                            end
                        end else begin
                            ml_next = ml_reg + 4'd1;
                        end
                    end else begin
                        sec_next = sec_reg + 6'd1;
                    end
                end
            end

            SET: begin
                mode_next = MODE_SET;
                if (btn_set) begin
                    state_next     = RUN;
                    mode_next      = MODE_RUN;
                    location_next  = 2'd0;
                    blank_next     = 1'b0;
                    blink_cnt_next = '0;
                end else if (btn_next) begin
                    location_next  = location_reg + 2'd1;
                    blank_next     = 1'b0;
                    blink_cnt_next = '0;
                end else if (btn_inc) begin
                    blank_next     = 1'b0;
                    blink_cnt_next = '0;
                    // Each digit wraps on its own; edits never carry into neighbours.
                    case (location_reg)
                        2'd0: begin
                            if (hu_reg >= 4'd2) begin
                                hu_next = 4'd0;
                            end else begin
                                hu_next = hu_reg + 4'd1;
                                if (hu_reg == 4'd1 && hl_reg > 4'd3)
                                    hl_next = 4'd3;
                            end
                        end
                        2'd1: hl_next = (hl_reg >= hl_limit) ? 4'd0 : hl_reg + 4'd1;
                        2'd2: mu_next = (mu_reg >= 4'd5) ? 4'd0 : mu_reg + 4'd1;
                        default: ml_next = (ml_reg >= 4'd9) ? 4'd0 : ml_reg + 4'd1;
                    endcase
                end else begin
                    if (blink_cnt_reg == CNT_LAST) begin
                        blink_cnt_next = '0;
                        blank_next     = ~blank_reg;
                    end else begin
                        blink_cnt_next = blink_cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = RUN;
                mode_next  = MODE_RUN;
            end
        endcase
    end

    assign mode         = mode_reg;
    assign location     = location_reg;
    assign hoursUpper   = hu_reg;
    assign hoursLower   = hl_reg;
    assign minutesUpper = mu_reg;
    assign minutesLower = ml_reg;
    assign seconds      = sec_reg;
    assign blank        = blank_reg;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with a short blink period.
// Inputs change on the falling edge, and outputs are sampled on the falling edge after the acting rising edge.
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick, btn_set, btn_next, btn_inc;
    logic [1:0] mode, location;
    logic [3:0] hoursUpper, hoursLower, minutesUpper, minutesLower;
    logic [5:0] seconds;
    logic       blank;

    int tests = 0;
    int failures = 0;
    int e;

    clock_set_controller #(.BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .btn_set(btn_set),
        .btn_next(btn_next), .btn_inc(btn_inc), .mode(mode), .location(location),
        .hoursUpper(hoursUpper), .hoursLower(hoursLower),
        .minutesUpper(minutesUpper), .minutesLower(minutesLower),
        .seconds(seconds), .blank(blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int hu, input int hl, input int mu, input int ml);
        check({tag, "_hu"}, hoursUpper, hu);
        check({tag, "_hl"}, hoursLower, hl);
        check({tag, "_mu"}, minutesUpper, mu);
        check({tag, "_ml"}, minutesLower, ml);
    endtask

    // Called on a falling edge: holds one pulse across a rising edge, then clears it.
    task automatic press(input logic s, input logic n, input logic i, input logic t);
        btn_set = s; btn_next = n; btn_inc = i; sec_tick = t;
        @(negedge clk);
        btn_set = 0; btn_next = 0; btn_inc = 0; sec_tick = 0;
        $display("[TB] set=%0b next=%0b inc=%0b tick=%0b -> mode=%0d loc=%0d %0d%0d:%0d%0d:%0d blank=%0b",
                 s, n, i, t, mode, location, hoursUpper, hoursLower,
                 minutesUpper, minutesLower, seconds, blank);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; sec_tick = 0; btn_set = 0; btn_next = 0; btn_inc = 0;
        idle(3);
        rst = 0;
        check("rst_mode", mode, 2'b01);
        check("rst_loc", location, 0);
        check("rst_sec", seconds, 0);
        check("rst_blank", blank, 0);
        check_time("rst", 0, 0, 0, 0);

        // RUN ignores edit buttons but counts ticks.
        press(0, 1, 1, 0);
        check("run_ignore_loc", location, 0);
        check_time("run_ignore", 0, 0, 0, 0);
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        press(0, 1, 1, 1);
        check("run_sec3", seconds, 3);
        check("run_sec3_loc", location, 0);

        // Preset 23:59 in SET.
        press(1, 0, 0, 0);
        check("set_mode", mode, 2'b00);
        check("set_sec_clr", seconds, 0);
        check("set_loc", location, 0);
        repeat (2) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (3) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (5) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (9) press(0, 0, 1, 0);
        check_time("preset", 2, 3, 5, 9);
        press(1, 0, 0, 0);
        check("back_run_mode", mode, 2'b01);
        check("back_run_loc", location, 0);
        check("back_run_blank", blank, 0);
        check("back_run_sec", seconds, 0);
        repeat (59) press(0, 0, 0, 1);
        check("sec59", seconds, 59);
        check_time("pre_roll", 2, 3, 5, 9);
        press(0, 0, 0, 1);
        check_time("rollover", 0, 0, 0, 0);
        check("rollover_sec", seconds, 0);
        check("rollover_mode", mode, 2'b01);
        repeat (60) press(0, 0, 0, 1);
        check_time("min_carry", 0, 0, 0, 1);
        check("min_carry_sec", seconds, 0);

        // Hour clamp: 19 -> 23 -> 03.
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (9) press(0, 0, 1, 0);
        check_time("pre_clamp", 1, 9, 0, 1);
        repeat (3) press(0, 1, 0, 0);
        check("clamp_loc0", location, 0);
        press(0, 0, 1, 0);
        check("clamp_hu2", hoursUpper, 2);
        check("clamp_hl3", hoursLower, 3);
        press(0, 0, 1, 0);
        check("wrap_hu0", hoursUpper, 0);
        check("wrap_hl3", hoursLower, 3);

        // Navigation wraps 3 -> 0.
        press(0, 1, 0, 0); check("nav1", location, 1);
        press(0, 1, 0, 0); check("nav2", location, 2);
        press(0, 1, 0, 0); check("nav3", location, 3);
        press(0, 1, 0, 0); check("nav0", location, 0);

        // Blink: toggle on every 4th idle cycle; an edit forces it visible.
        idle(3); check("blink_c3", blank, 0);
        idle(1); check("blink_c4", blank, 1);
        idle(2); check("blink_c6", blank, 1);
        press(0, 0, 1, 0);
        check("blink_inc_clr", blank, 0);
        check("blink_inc_hu", hoursUpper, 1);
        idle(3); check("blink_restart3", blank, 0);
        idle(1); check("blink_restart4", blank, 1);

        // Priority.
        press(0, 1, 1, 0);
        check("prio_next_loc", location, 1);
        check("prio_next_hu", hoursUpper, 1);
        press(1, 1, 1, 0);
        check("prio_all_mode", mode, 2'b01);
        check("prio_all_loc", location, 0);
        check_time("prio_all", 1, 3, 0, 1);
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        check("prio_sec2", seconds, 2);
        press(1, 0, 0, 1);
        check("prio_tick_mode", mode, 2'b00);
        check("prio_tick_sec", seconds, 0);
        check_time("prio_tick", 1, 3, 0, 1);

        // Build 12:34, then reset asynchronously mid-cycle.
        press(0, 1, 0, 0);
        repeat (9) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (3) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (3) press(0, 0, 1, 0);
        check_time("pre_arst", 1, 2, 3, 4);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("arst_mode", mode, 2'b01);
        check("arst_loc", location, 0);
        check("arst_blank", blank, 0);
        check("arst_sec", seconds, 0);
        check_time("arst", 0, 0, 0, 0);
        @(negedge clk);
        press(1, 0, 1, 1);
        check("arst_hold_mode", mode, 2'b01);
        check("arst_hold_sec", seconds, 0);
        rst = 0;
        press(1, 0, 0, 0);
        check("post_rst_mode", mode, 2'b00);

        // Range sweeps, 60 increments per digit.
        e = 0;
        for (int k = 0; k < 60; k++) begin
            press(0, 0, 1, 0);
            e = (e == 2) ? 0 : e + 1;
            check("sweep_hu", hoursUpper, e);
            check("sweep_hu_nb", hoursLower, 0);
        end
        repeat (2) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        e = 0;
        for (int k = 0; k < 60; k++) begin
            press(0, 0, 1, 0);
            e = (e == 3) ? 0 : e + 1;
            check("sweep_hl", hoursLower, e);
            check("sweep_hl_nb", hoursUpper, 2);
        end
        press(0, 1, 0, 0);
        e = 0;
        for (int k = 0; k < 60; k++) begin
            press(0, 0, 1, 0);
            e = (e == 5) ? 0 : e + 1;
            check("sweep_mu", minutesUpper, e);
            check("sweep_mu_nb", minutesLower, 0);
        end
        press(0, 1, 0, 0);
        e = 0;
        for (int k = 0; k < 60; k++) begin
            press(0, 0, 1, 0);
            e = (e == 9) ? 0 : e + 1;
            check("sweep_ml", minutesLower, e);
            check("sweep_ml_nb", minutesUpper, 0);
        end
        check_time("sweep_end", 2, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
